// File: rtl/ctrl_pkg.sv
// Shared decode constants, the EX control bundle layout and the FSM state type
// used by the ID->EX control pipeline stage.
package ctrl_pkg;

    localparam logic [6:0] OP_NONE   = 7'b0000000;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
    localparam logic [1:0] ALUOP_MULDIV = 2'b11;

    typedef struct packed {
        logic       reg_write;
        logic [2:0] imm_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       mem_write;
        logic [1:0] result_src;
        logic       branch;
        logic [1:0] alu_op;
        logic       jump;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t BND_LOAD   = 14'b1_000_0_01_0_01_0_00_0;
    localparam ctrl_bundle_t BND_STORE  = 14'b0_001_0_01_1_00_0_00_0;
    localparam ctrl_bundle_t BND_R      = 14'b1_000_0_00_0_00_0_10_0;
    localparam ctrl_bundle_t BND_BRANCH = 14'b0_010_0_00_0_00_1_01_0;
    localparam ctrl_bundle_t BND_IMM    = 14'b1_000_0_01_0_00_0_10_0;
    localparam ctrl_bundle_t BND_JAL    = 14'b1_011_0_00_0_10_0_00_1;
    localparam ctrl_bundle_t BND_AUIPC  = 14'b1_100_1_10_0_00_0_00_0;
    localparam ctrl_bundle_t BND_LUI    = 14'b1_100_1_01_0_00_0_00_0;
    localparam ctrl_bundle_t BND_JALR   = 14'b1_000_0_01_0_10_0_00_1;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct7 decode into the EX control bundle, flagging
// M-extension ops, their divide/multiply class, bubbles and illegal encodings.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter bit EN_MEXT = 1'b1
) (
    input  logic [31:0]  instr_i,
    output ctrl_bundle_t bundle_o,
    output logic         muldiv_o,
    output logic         div_o,
    output logic         illegal_o,
    output logic         nop_o
);

    logic [6:0] op;
    logic [6:0] funct7;
    logic       unused_bits;

    assign op          = instr_i[6:0];
    assign funct7      = instr_i[31:25];
    assign div_o       = instr_i[14];
    assign unused_bits = ^{instr_i[24:15], instr_i[13:7]};

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        bundle_o  = '0;
        muldiv_o  = 1'b0;
        illegal_o = 1'b0;
        nop_o     = 1'b0;
        case (op)
            OP_LOAD:   bundle_o = BND_LOAD;
            OP_STORE:  bundle_o = BND_STORE;
            OP_BRANCH: bundle_o = BND_BRANCH;
            OP_IMM:    bundle_o = BND_IMM;
            OP_JAL:    bundle_o = BND_JAL;
            OP_AUIPC:  bundle_o = BND_AUIPC;
            OP_LUI:    bundle_o = BND_LUI;
            OP_JALR:   bundle_o = BND_JALR;
            OP_R: begin
                if (funct7 != F7_MULDIV) begin
                    bundle_o = BND_R;
                end else if (EN_MEXT) begin
                    bundle_o        = BND_R;
                    bundle_o.alu_op = ALUOP_MULDIV;
                    muldiv_o        = 1'b1;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OP_NONE:   nop_o     = 1'b1;
            default:   illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe_stage.sv
// ID->EX control register stage: registers the decoded bundle, holds multi-cycle
// M-ops in BUSY for their latency and produces backpressure to IF/ID.
module ctrl_pipe_stage
    import ctrl_pkg::*;
#(
    parameter bit          EN_MEXT = 1'b1,
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned DIV_LAT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        in_valid,
    input  logic        stall_ex,
    input  logic        flush,
    output logic        RegWriteE,
    output logic [2:0]  ImmSrcE,
    output logic        ALUSrcAE,
    output logic [1:0]  ALUSrcBE,
    output logic        MemWriteE,
    output logic [1:0]  ResultSrcE,
    output logic        BranchE,
    output logic [1:0]  ALUOpE,
    output logic        JumpE,
    output logic        MulDivE,
    output logic        out_valid,
    output logic        illegal,
    output logic        stall_id
);

    // Sized for the longer of the two latencies so an oversized MUL_LAT cannot truncate.
    localparam int unsigned MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ctrl_bundle_t     dec_bundle;
    logic             dec_muldiv;
    logic             dec_div;
    logic             dec_illegal;
    logic             dec_nop;
    logic [CNT_W-1:0] lat_load;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    ctrl_bundle_t     bundle_q;
    ctrl_bundle_t     pend_q;
    logic             muldiv_q;
    logic             valid_q;
    logic             illegal_q;

    ctrl_decode #(.EN_MEXT(EN_MEXT)) u_decode (
        .instr_i   (instr),
        .bundle_o  (dec_bundle),
        .muldiv_o  (dec_muldiv),
        .div_o     (dec_div),
        .illegal_o (dec_illegal),
        .nop_o     (dec_nop)
    );

    assign lat_load = dec_div ? DIV_LOAD : MUL_LOAD;
    assign stall_id = (state_q == ST_BUSY) | stall_ex;

    // NOTE: all state below is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bundle_q  <= '0;
            pend_q    <= '0;
            muldiv_q  <= 1'b0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (flush) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bundle_q  <= '0;
            muldiv_q  <= 1'b0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (stall_ex) begin
                        illegal_q <= 1'b0;
                    end else begin
                        bundle_q  <= '0;
                        muldiv_q  <= 1'b0;
                        valid_q   <= 1'b0;
                        illegal_q <= 1'b0;
                        if (in_valid) begin
                            if (dec_illegal) begin
                                illegal_q <= 1'b1;
                            end else if (dec_muldiv && (lat_load != '0)) begin
                                state_q <= ST_BUSY;
                                cnt_q   <= lat_load;
                                pend_q  <= dec_bundle;
                            end else if (!dec_nop) begin
                                bundle_q <= dec_bundle;
                                muldiv_q <= dec_muldiv;
                                valid_q  <= 1'b1;
                            end
                        end
                    end
                end
                ST_BUSY: begin
                    // Issue on the cycle the count reaches zero; a stall parks the counter at zero.
                    if ((cnt_q <= CNT_ONE) && !stall_ex) begin
                        state_q  <= ST_IDLE;
                        cnt_q    <= '0;
                        bundle_q <= pend_q;
                        muldiv_q <= 1'b1;
                        valid_q  <= 1'b1;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign RegWriteE  = bundle_q.reg_write;
    assign ImmSrcE    = bundle_q.imm_src;
    assign ALUSrcAE   = bundle_q.alu_src_a;
    assign ALUSrcBE   = bundle_q.alu_src_b;
    assign MemWriteE  = bundle_q.mem_write;
    assign ResultSrcE = bundle_q.result_src;
    assign BranchE    = bundle_q.branch;
    assign ALUOpE     = bundle_q.alu_op;
    assign JumpE      = bundle_q.jump;
    assign MulDivE    = muldiv_q;
    assign out_valid  = valid_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_ctrl_pipe_stage.sv
// Scoreboard bench for ctrl_pipe_stage: one M-enabled instance carries the main
// checks, a second instance with EN_MEXT=0 covers the illegal-M path.
module tb_ctrl_pipe_stage;

    localparam int unsigned MUL_LAT = 2;
    localparam int unsigned DIV_LAT = 8;

    localparam logic [31:0] I_LW    = 32'h00012083;
    localparam logic [31:0] I_SW    = 32'h0020A023;
    localparam logic [31:0] I_ADD   = 32'h003100B3;
    localparam logic [31:0] I_MUL   = 32'h021100B3;
    localparam logic [31:0] I_MULHU = 32'h023130B3;
    localparam logic [31:0] I_DIVU  = 32'h023150B3;
    localparam logic [31:0] I_REM   = 32'h023160B3;

    localparam logic [13:0] B_LW  = 14'b1_000_0_01_0_01_0_00_0;
    localparam logic [13:0] B_SW  = 14'b0_001_0_01_1_00_0_00_0;
    localparam logic [13:0] B_R   = 14'b1_000_0_00_0_00_0_10_0;
    localparam logic [13:0] B_M   = 14'b1_000_0_00_0_00_0_11_0;

    logic        clk = 1'b0;
    logic        reset, in_valid, stall_ex, flush;
    logic [31:0] instr;

    logic       RegWriteE, ALUSrcAE, MemWriteE, BranchE, JumpE, MulDivE, out_valid, illegal, stall_id;
    logic [2:0] ImmSrcE;
    logic [1:0] ALUSrcBE, ResultSrcE, ALUOpE;

    logic       n_RegWriteE, n_ALUSrcAE, n_MemWriteE, n_BranchE, n_JumpE, n_MulDivE, n_out_valid, n_illegal, n_stall_id;
    logic [2:0] n_ImmSrcE;
    logic [1:0] n_ALUSrcBE, n_ResultSrcE, n_ALUOpE;

    typedef struct packed {
        logic [13:0] b;
        logic        m;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    wire [13:0] obs_b = {RegWriteE, ImmSrcE, ALUSrcAE, ALUSrcBE, MemWriteE, ResultSrcE, BranchE, ALUOpE, JumpE};
    wire [13:0] nm_b  = {n_RegWriteE, n_ImmSrcE, n_ALUSrcAE, n_ALUSrcBE, n_MemWriteE, n_ResultSrcE,
                         n_BranchE, n_ALUOpE, n_JumpE};

    ctrl_pipe_stage #(.EN_MEXT(1'b1), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .instr(instr), .in_valid(in_valid), .stall_ex(stall_ex), .flush(flush),
        .RegWriteE(RegWriteE), .ImmSrcE(ImmSrcE), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
        .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUOpE(ALUOpE), .JumpE(JumpE),
        .MulDivE(MulDivE), .out_valid(out_valid), .illegal(illegal), .stall_id(stall_id)
    );

    ctrl_pipe_stage #(.EN_MEXT(1'b0), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut_nm (
        .clk(clk), .reset(reset), .instr(instr), .in_valid(in_valid), .stall_ex(stall_ex), .flush(flush),
        .RegWriteE(n_RegWriteE), .ImmSrcE(n_ImmSrcE), .ALUSrcAE(n_ALUSrcAE), .ALUSrcBE(n_ALUSrcBE),
        .MemWriteE(n_MemWriteE), .ResultSrcE(n_ResultSrcE), .BranchE(n_BranchE), .ALUOpE(n_ALUOpE),
        .JumpE(n_JumpE), .MulDivE(n_MulDivE), .out_valid(n_out_valid), .illegal(n_illegal), .stall_id(n_stall_id)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [13:0] ref_bundle(input logic [6:0] op);
        case (op)
            7'b0000011: return B_LW;
            7'b0100011: return B_SW;
            7'b0110011: return B_R;
            7'b1100011: return 14'b0_010_0_00_0_00_1_01_0;
            7'b0010011: return 14'b1_000_0_01_0_00_0_10_0;
            7'b1101111: return 14'b1_011_0_00_0_10_0_00_1;
            7'b0010111: return 14'b1_100_1_10_0_00_0_00_0;
            7'b0110111: return 14'b1_100_1_01_0_00_0_00_0;
            7'b1100111: return 14'b1_000_0_01_0_10_0_00_1;
            default:    return 14'b0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b1; stall_ex = 1'b1; in_valid = 1'b1; instr = I_LW;
        step();
        vectors++;
        if ({obs_b, MulDivE, out_valid, illegal} !== 17'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0", {obs_b, MulDivE, out_valid, illegal});
        end
        vectors++;
        if (stall_id !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_stall_hi: stall_id=%b want 1", stall_id);
        end
        stall_ex = 1'b0;
        #1;
        vectors++;
        if (stall_id !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_stall_lo: stall_id=%b want 0", stall_id);
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011,
                                7'b1101111, 7'b0010111, 7'b0110111, 7'b1100111};
        exp_t e;
        for (int i = 0; i < 9; i++) begin
            instr = $urandom();
            instr[6:0] = ops[i];
            if (ops[i] == 7'b0110011) instr[31:25] = (i % 2 == 0) ? 7'b0000000 : 7'b0100000;
            if (i == 0) instr = I_LW;
            in_valid = 1'b1;
            sb.push_back('{ref_bundle(ops[i]), 1'b0});
            #1;
            vectors++;
            if (stall_id !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_stall_id op=%b: stall_id=%b want 0", ops[i], stall_id);
            end
            step();
            vectors++;
            if (out_valid !== 1'b1 || illegal !== 1'b0 || sb.size() == 0) begin
                miscompares++;
                $display("FAIL b2b_valid op=%b: out_valid=%b illegal=%b want 1/0", ops[i], out_valid, illegal);
                if (sb.size() != 0) void'(sb.pop_front());
            end else begin
                e = sb.pop_front();
                if ({obs_b, MulDivE} !== {e.b, e.m}) begin
                    miscompares++;
                    $display("FAIL b2b_bundle op=%b: got %b/%b want %b/%b", ops[i], obs_b, MulDivE, e.b, e.m);
                end
            end
        end
        in_valid = 1'b0;
        step();
        vectors++;
        if (out_valid !== 1'b0 || obs_b !== 14'b0) begin
            miscompares++;
            $display("FAIL b2b_drain: out_valid=%b bundle=%b want 0", out_valid, obs_b);
        end
    endtask

    task automatic test_bubble_illegal();
        logic [31:0] vec [3] = '{I_LW, 32'h12345000, 32'h0000007F};
        logic        val [3] = '{1'b0, 1'b1, 1'b1};
        logic        ill [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            instr = vec[i]; in_valid = val[i];
            step();
            vectors++;
            if ({obs_b, MulDivE, out_valid} !== 16'b0 || illegal !== ill[i]) begin
                miscompares++;
                $display("FAIL bubble_%0d: bundle=%b valid=%b illegal=%b want 0/0/%b", i, obs_b, out_valid, illegal, ill[i]);
            end
        end
        in_valid = 1'b0;
        step();
        vectors++;
        if (illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_pulse: illegal=%b want 0 on second cycle", illegal);
        end
    endtask

    task automatic test_muldiv(input string name, input logic [31:0] ins, input int unsigned lat_exp);
        int   lat, busy;
        exp_t e;
        instr = ins; in_valid = 1'b1;
        sb.push_back('{B_M, 1'b1});
        step();
        in_valid = 1'b0;
        lat = 1; busy = 0;
        while (out_valid !== 1'b1 && lat < 64) begin
            if (stall_id === 1'b1) busy++;
            step();
            lat++;
        end
        vectors++;
        if (lat != int'(lat_exp) || busy != int'(lat_exp) - 1) begin
            miscompares++;
            $display("FAIL %s_latency: issue cycle %0d stall cycles %0d want %0d/%0d", name, lat, busy, lat_exp, lat_exp - 1);
        end
        vectors++;
        if (sb.size() == 0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_issue: out_valid=%b queue=%0d", name, out_valid, sb.size());
            if (sb.size() != 0) void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            if ({obs_b, MulDivE, stall_id} !== {e.b, e.m, 1'b0}) begin
                miscompares++;
                $display("FAIL %s_bundle: got %b/%b stall_id=%b want %b/%b/0", name, obs_b, MulDivE, stall_id, e.b, e.m);
            end
        end
        step();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_single_pulse: out_valid=%b want 0", name, out_valid);
        end
    endtask

    task automatic test_mext_off();
        instr = I_MUL; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        vectors++;
        if ({n_illegal, n_out_valid, n_MulDivE, nm_b} !== {1'b1, 16'b0} || illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL mext_off_illegal: illegal=%b valid=%b bundle=%b m_on_illegal=%b want 1/0/0/0",
                     n_illegal, n_out_valid, nm_b, illegal);
        end
        step();
        vectors++;
        if (n_illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL mext_off_pulse: illegal=%b want 0", n_illegal);
        end
        repeat (MUL_LAT + 1) step();
    endtask

    task automatic test_flush();
        exp_t e;
        instr = I_MUL; in_valid = 1'b1;
        step();
        in_valid = 1'b0; flush = 1'b1;
        #1;
        vectors++;
        if (stall_id !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_busy: stall_id=%b want 1", stall_id);
        end
        step();
        flush = 1'b0;
        vectors++;
        if ({obs_b, MulDivE, out_valid, illegal, stall_id} !== 18'b0) begin
            miscompares++;
            $display("FAIL flush_bubble: bundle=%b valid=%b stall_id=%b want 0", obs_b, out_valid, stall_id);
        end
        instr = I_ADD; in_valid = 1'b1;
        sb.push_back('{B_R, 1'b0});
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            miscompares++;
            $display("FAIL flush_add_issue: out_valid=%b want 1", out_valid);
            if (sb.size() != 0) void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            if ({obs_b, MulDivE} !== {e.b, e.m}) begin
                miscompares++;
                $display("FAIL flush_add_bundle: got %b/%b want %b/%b", obs_b, MulDivE, e.b, e.m);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL flush_no_stale_%0d: out_valid=%b want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_stall_busy();
        exp_t e;
        int   pulses;
        instr = I_MUL; in_valid = 1'b1;
        sb.push_back('{B_M, 1'b1});
        step();
        in_valid = 1'b0; stall_ex = 1'b1;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (out_valid !== 1'b0 || stall_id !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_busy_hold_%0d: out_valid=%b stall_id=%b want 0/1", i, out_valid, stall_id);
            end
            step();
        end
        stall_ex = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_busy_early: out_valid=%b want 0", out_valid);
        end
        step();
        vectors++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            miscompares++;
            $display("FAIL stall_busy_issue: out_valid=%b want 1", out_valid);
            if (sb.size() != 0) void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            if ({obs_b, MulDivE} !== {e.b, e.m}) begin
                miscompares++;
                $display("FAIL stall_busy_bundle: got %b/%b want %b/%b", obs_b, MulDivE, e.b, e.m);
            end
        end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (out_valid === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL stall_busy_pulses: extra pulses %0d want 0", pulses);
        end
    endtask

    task automatic test_idle_stall();
        exp_t e;
        instr = I_LW; in_valid = 1'b1;
        sb.push_back('{B_LW, 1'b0});
        step();
        e = sb.pop_front();
        stall_ex = 1'b1; instr = I_SW;
        for (int i = 0; i < 2; i++) begin
            step();
            vectors++;
            if ({obs_b, out_valid, stall_id} !== {e.b, 1'b1, 1'b1}) begin
                miscompares++;
                $display("FAIL idle_stall_hold_%0d: bundle=%b valid=%b stall_id=%b want %b/1/1",
                         i, obs_b, out_valid, stall_id, e.b);
            end
        end
        stall_ex = 1'b0;
        sb.push_back('{B_SW, 1'b0});
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || sb.size() == 0) begin
            miscompares++;
            $display("FAIL idle_stall_release: out_valid=%b want 1", out_valid);
            if (sb.size() != 0) void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            if ({obs_b, MulDivE} !== {e.b, e.m}) begin
                miscompares++;
                $display("FAIL idle_stall_bundle: got %b/%b want %b/%b", obs_b, MulDivE, e.b, e.m);
            end
        end
        step();
    endtask

    task automatic test_reset_busy();
        int stale;
        instr = I_DIVU; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (3) step();
        reset = 1'b1; stall_ex = 1'b1;
        step();
        vectors++;
        if ({obs_b, MulDivE, out_valid, illegal, stall_id} !== {17'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_busy_outputs: bundle=%b valid=%b stall_id=%b want 0/0/1", obs_b, out_valid, stall_id);
        end
        stall_ex = 1'b0;
        #1;
        vectors++;
        if (stall_id !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy_stall: stall_id=%b want 0", stall_id);
        end
        reset = 1'b0;
        stale = 0;
        for (int i = 0; i < int'(DIV_LAT) + 2; i++) begin
            step();
            if (out_valid === 1'b1) stale++;
        end
        vectors++;
        if (stale != 0) begin
            miscompares++;
            $display("FAIL reset_busy_stale: %0d stale issues want 0", stale);
        end
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; stall_ex = 1'b0; in_valid = 1'b0; instr = 32'h0;
        test_reset();
        test_back_to_back();
        test_bubble_illegal();
        test_muldiv("mul", I_MUL, MUL_LAT);
        test_muldiv("mulhu", I_MULHU, MUL_LAT);
        test_muldiv("divu", I_DIVU, DIV_LAT);
        test_muldiv("rem", I_REM, DIV_LAT);
        test_mext_off();
        test_flush();
        test_stall_busy();
        test_idle_stall();
        test_reset_busy();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: %0d entries left want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_stage.md
CTRL_PIPE_STAGE -- requirements
Module: ctrl_pipe_stage

Interface
REQ-001 Parameter EN_MEXT, default 1: 1 decodes RV32M ops; 0 treats them as illegal.
REQ-002 Parameter MUL_LAT, default 2: cycles from accept to issue for MUL/MULH/MULHSU/MULHU; legal range 1 or more.
REQ-003 Parameter DIV_LAT, default 8: cycles from accept to issue for DIV/DIVU/REM/REMU; legal range 1 or more.
REQ-004 clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 instr  in  32  ID-stage instruction; fields op[6:0], funct3[14:12], funct7[31:25].
REQ-007 in_valid  in  1  instr is valid this cycle.
REQ-008 stall_ex  in  1  downstream hold request from the hazard unit.
REQ-009 flush  in  1  kill the instruction in flight (branch taken / jump).
REQ-010 RegWriteE, ImmSrcE[2:0], ALUSrcAE, ALUSrcBE[1:0], MemWriteE, ResultSrcE[1:0], BranchE, ALUOpE[1:0], JumpE  out  registered control bundle to EX.
REQ-011 MulDivE  out  1  bundle belongs to an M-extension op.
REQ-012 out_valid  out  1  bundle is a real instruction.
REQ-013 illegal  out  1  one-cycle pulse, registered, for an undecodable instruction.
REQ-014 stall_id  out  1  combinational backpressure to IF/ID; high means hold instr.

Function
REQ-015 Bundle order SHALL be {RegWrite,ImmSrc,ALUSrcA,ALUSrcB,MemWrite,ResultSrc,Branch,ALUOp,Jump}.
REQ-016 Bundle values by op:
- lw 0000011 = 1_000_0_01_0_01_0_00_0
- sw 0100011 = 0_001_0_01_1_00_0_00_0
- R 0110011 = 1_000_0_00_0_00_0_10_0
- B 1100011 = 0_010_0_00_0_00_1_01_0
- I-ALU 0010011 = 1_000_0_01_0_00_0_10_0
- jal 1101111 = 1_011_0_00_0_10_0_00_1
- auipc 0010111 = 1_100_1_10_0_00_0_00_0
- lui 0110111 = 1_100_1_01_0_00_0_00_0
- jalr 1100111 = 1_000_0_01_0_10_0_00_1
REQ-017 An R-type with funct7=0000001 and EN_MEXT=1 is an M-op: R-type bundle with ALUOp=11 and MulDivE=1; funct3[2]=1 selects DIV_LAT, otherwise MUL_LAT.
REQ-018 An R-type with funct7=0000001 and EN_MEXT=0, or any unlisted op other than 0000000, is illegal: next cycle bundle all-zero, out_valid=0, illegal=1.
REQ-019 op=0000000 or in_valid=0 SHALL register a bubble: all-zero bundle, out_valid=0, illegal=0.
REQ-020 State machine IDLE/BUSY with a down-counter of width $clog2(DIV_LAT+1).
REQ-021 In IDLE with stall_id=0, non-M ops and M-ops with latency 1 SHALL register next cycle with out_valid=1 (latency 1).
REQ-022 An accepted M-op with latency L>1 SHALL load counter=L-1 and go to BUSY; the output is a bubble while BUSY.
REQ-023 In BUSY the counter decrements each cycle. At 0 with stall_ex=0: issue the M bundle with out_valid=1 and return to IDLE. At 0 with stall_ex=1: stay in BUSY at 0.
REQ-024 stall_id = (state==BUSY) | stall_ex.
REQ-025 In IDLE with stall_ex=1, the output registers SHALL hold their value; instr is not consumed.
REQ-026 flush has priority over stall_ex and BUSY: next cycle bubble, state IDLE, counter 0, illegal 0.

Reset
REQ-027 On reset=1 at an edge: all bundle outputs 0, MulDivE=0, out_valid=0, illegal=0, state IDLE, counter 0. Reset overrides flush and stall.
REQ-028 During reset cycles stall_id SHALL equal stall_ex.

Structure
REQ-029 Package ctrl_pkg SHALL hold opcode localparams, ALUOp encodings (incl. 2'b11 MULDIV), the packed ctrl_bundle_t struct in REQ-015 order, and the state enum.
REQ-030 Combinational decode (REQ-016..018) SHALL be the sub-module ctrl_decode; ctrl_pipe_stage holds the FSM, counter and registers.

Verification
REQ-031 Reset, then lw 0x00012083 valid -> next cycle bundle 1_000_0_01_0_01_0_00_0, out_valid=1, stall_id=0.
REQ-032 DIVU x1,x2,x3 (0x023150B3), DIV_LAT=8 -> stall_id high 7 cycles, out_valid=1 on cycle 8 with ALUOp=11 and MulDivE=1.
REQ-033 EN_MEXT=0, MUL 0x021100B3 -> illegal=1 for exactly one cycle, out_valid=0, bundle zero.
REQ-034 MUL in BUSY with flush asserted on cycle 1 -> next cycle bubble, stall_id=0, state IDLE; a following add issues with latency 1.
REQ-035 MUL (MUL_LAT=2) with stall_ex held 3 cycles from accept -> issue on the first cycle after stall_ex falls; exactly one out_valid pulse.
REQ-036 Reset asserted mid-BUSY -> next cycle all outputs 0, stall_id=stall_ex.
